// File: rtl/ypc_pkg.sv
// -----------------------------------------------------------------------------
// ypc_pkg
// Shared definitions for the ypc fetch front end.
//   state_e          : fetch FSM states (FAULT is reachable only when
//                      IFU_MISALIGN_CHECK_EN is defined)
//   DEFAULT_RESET_PC : first fetch address after reset
//   INST_BYTES       : PC increment per instruction
// -----------------------------------------------------------------------------
package ypc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD,
      FAULT
   } state_e;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
   localparam logic [31:0] INST_BYTES       = 32'd4;

endpackage

// File: rtl/ifu.sv
// -----------------------------------------------------------------------------
// ifu -- instruction fetch unit
// Holds the PC, fetches one instruction at a time from instruction memory and
// presents it with its PC to the decoder. Redirects from execute replace the
// fetch PC and squash any stale instruction.
//
// Configuration macro: IFU_MISALIGN_CHECK_EN
//   defined   : a redirect with redirect_pc[1:0] != 0 parks the unit in FAULT
//               (fault = 1 until reset, no requests, no instructions)
//   undefined : redirect_pc[1:0] is forced to 0 and fault is tied 0
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   mem_req_*       fetch request (valid/ready), 4-byte aligned address
//   mem_rsp_*       fetch response, one per accepted request, >= 1 cycle later
//   inst_*          instruction + PC to decoder (valid/ready)
//   redirect_*      one-cycle redirect pulse and target from execute
//   fault           sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module ifu
   import ypc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [31:0]           mem_req_addr,
   input  logic                  mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] mem_rsp_data,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [DATA_WIDTH-1:0] inst,
   output logic [31:0]           inst_pc,
   input  logic                  redirect_valid,
   input  logic [31:0]           redirect_pc,
   output logic                  fault
);

   state_e                r_state;
   logic [31:0]           r_pc;
   logic [31:0]           r_tgt;
   logic                  r_stale;
   logic [DATA_WIDTH-1:0] r_inst;
   logic [31:0]           r_inst_pc;

   state_e                w_state_nxt;
   logic [31:0]           w_pc_nxt;
   logic [31:0]           w_tgt_nxt;
   logic                  w_stale_nxt;
   logic [DATA_WIDTH-1:0] w_inst_nxt;
   logic [31:0]           w_inst_pc_nxt;
   logic [31:0]           w_redir_pc;
   logic                  w_misalign;

`ifdef IFU_MISALIGN_CHECK_EN
   assign w_redir_pc = redirect_pc;
   assign w_misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign fault      = (r_state == FAULT);
`else
   // Low bits are dropped so a misaligned target fetches its containing word.
   assign w_redir_pc = redirect_pc & ~32'h0000_0003;
   assign w_misalign = 1'b0;
   assign fault      = 1'b0;
`endif

   // NOTE: state and datapath registers use non-blocking assignments so every
   // register samples the values from before the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_pc      <= RESET_PC;
         r_tgt     <= RESET_PC;
         r_stale   <= 1'b0;
         r_inst    <= '0;
         r_inst_pc <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_tgt     <= w_tgt_nxt;
         r_stale   <= w_stale_nxt;
         r_inst    <= w_inst_nxt;
         r_inst_pc <= w_inst_pc_nxt;
      end
   end

   always_comb begin
      // NOTE: every output of this block is given a default first, so no path
      // through the case statement can leave a value unassigned (no latches).
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc;
      w_tgt_nxt     = r_tgt;
      w_stale_nxt   = r_stale;
      w_inst_nxt    = r_inst;
      w_inst_pc_nxt = r_inst_pc;
      mem_req_valid = 1'b0;
      inst_valid    = 1'b0;

      case (r_state)
         IDLE: begin
            w_state_nxt = REQ;
            if (redirect_valid) begin
               w_pc_nxt = w_redir_pc;
            end
         end

         REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               w_state_nxt = WAIT;
            end
            // The address must stay put until accepted, so the target is
            // parked and the in-flight fetch is discarded later.
            if (redirect_valid) begin
               w_tgt_nxt   = w_redir_pc;
               w_stale_nxt = 1'b1;
            end
         end

         WAIT: begin
            if (redirect_valid) begin
               w_tgt_nxt   = w_redir_pc;
               w_stale_nxt = 1'b1;
            end
            if (mem_rsp_valid) begin
               // A redirect landing together with the response also makes it
               // stale; the newest target wins over any parked one.
               if (r_stale || redirect_valid) begin
                  w_state_nxt = REQ;
                  w_pc_nxt    = redirect_valid ? w_redir_pc : r_tgt;
                  w_stale_nxt = 1'b0;
               end else begin
                  w_state_nxt   = HOLD;
                  w_inst_nxt    = mem_rsp_data;
                  w_inst_pc_nxt = r_pc;
               end
            end
         end

         HOLD: begin
            inst_valid = 1'b1;
            // Redirect squashes the held instruction even if it is accepted.
            if (redirect_valid) begin
               w_state_nxt = REQ;
               w_pc_nxt    = w_redir_pc;
               w_stale_nxt = 1'b0;
            end else if (inst_ready) begin
               w_state_nxt = REQ;
               w_pc_nxt    = r_pc + INST_BYTES;
            end
         end

         FAULT: begin
            w_state_nxt = FAULT;
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      if (w_misalign) begin
         w_state_nxt = FAULT;
      end
   end

   assign mem_req_addr = r_pc;
   assign inst         = r_inst;
   assign inst_pc      = r_inst_pc;

endmodule

// File: tb/tb_ifu.sv
// -----------------------------------------------------------------------------
// tb_ifu -- self-checking bench for ifu
// A one-cycle-latency memory model answers every accepted request. Expected
// request addresses and expected delivered instructions are queued as each
// directed step is set up and popped when the DUT shows the matching event.
// Honours IFU_MISALIGN_CHECK_EN for the misaligned-redirect step.
// -----------------------------------------------------------------------------
module tb_ifu;

   typedef struct {
      logic [31:0] data;
      logic [31:0] pc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_data = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        fault;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc   = 0;

   logic [31:0] exp_addr[$];
   exp_t        exp_inst[$];
   int          hs_cyc[$];

   ifu #(
      .DATA_WIDTH (32),
      .RESET_PC   (32'h8000_0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fault          (fault)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mk_data(input logic [31:0] a);
      return {a[15:0], 16'h0013};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Queue one expected fetch; keep=0 means the response must be discarded.
   task automatic expect_fetch(input logic [31:0] a, input bit keep);
      exp_t e;
      exp_addr.push_back(a);
      if (keep) begin
         e.data = mk_data(a);
         e.pc   = a;
         exp_inst.push_back(e);
      end
   endtask

   // One clock: score the handshakes of the ending cycle, advance, then let the
   // memory model answer what was accepted at this edge.
   task automatic tick();
      logic        acc;
      logic [31:0] a;
      exp_t        e;
      acc = mem_req_valid && mem_req_ready;
      a   = mem_req_addr;
      if (acc) begin
         if (exp_addr.size() == 0) check("req_unexpected", a, 32'hDEAD_BEEF);
         else                      check("req_addr", a, exp_addr.pop_front());
      end
      if (inst_valid && inst_ready && !redirect_valid) begin
         hs_cyc.push_back(cyc);
         if (exp_inst.size() == 0) begin
            check("inst_unexpected", inst_pc, 32'hDEAD_BEEF);
         end else begin
            e = exp_inst.pop_front();
            check("inst", inst, e.data);
            check("inst_pc", inst_pc, e.pc);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      mem_rsp_valid  = acc;
      mem_rsp_data   = acc ? mk_data(a) : 32'h0;
      redirect_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((exp_addr.size() != 0 || exp_inst.size() != 0) && n < 40) begin
         tick();
         n++;
      end
      if (exp_addr.size() != 0 || exp_inst.size() != 0) begin
         check({tag, "_drain_timeout"}, exp_addr.size() + exp_inst.size(), 0);
         exp_addr.delete();
         exp_inst.delete();
      end
   endtask

   task automatic wait_inst_valid(input string tag);
      int n;
      n = 0;
      while (!inst_valid && n < 20) begin
         tick();
         n++;
      end
      if (!inst_valid) check({tag, "_inst_valid_timeout"}, {31'b0, inst_valid}, 1);
   endtask

   task automatic redirect(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
   endtask

   initial begin
      // ---------------- reset values ----------------
      repeat (2) @(posedge clk);
      #1;
      check("rst_mem_req_valid", {31'b0, mem_req_valid}, 0);
      check("rst_inst_valid",    {31'b0, inst_valid},    0);
      check("rst_inst",          inst,                   0);
      check("rst_inst_pc",       inst_pc,                0);
      check("rst_fault",         {31'b0, fault},         0);
      check("rst_pc",            mem_req_addr,           32'h8000_0000);
      rst           = 1'b0;
      mem_req_ready = 1'b1;
      inst_ready    = 1'b1;
      tick();
      check("first_req_valid", {31'b0, mem_req_valid}, 1);

      // ---------------- 1: sequential fetch ----------------
      hs_cyc.delete();
      expect_fetch(32'h8000_0000, 1'b1);
      expect_fetch(32'h8000_0004, 1'b1);
      expect_fetch(32'h8000_0008, 1'b1);
      drain("seq");
      check("seq_hs_count", hs_cyc.size(), 3);
      if (hs_cyc.size() == 3) begin
         check("seq_spacing_0", hs_cyc[1] - hs_cyc[0], 3);
         check("seq_spacing_1", hs_cyc[2] - hs_cyc[1], 3);
      end

      // ---------------- 2: decoder backpressure ----------------
      inst_ready = 1'b0;
      expect_fetch(32'h8000_000C, 1'b0);
      wait_inst_valid("bp");
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_inst_valid",  {31'b0, inst_valid},    1);
         check("bp_inst_stable", inst,                   mk_data(32'h8000_000C));
         check("bp_pc_stable",   inst_pc,                32'h8000_000C);
         check("bp_no_req",      {31'b0, mem_req_valid}, 0);
      end
      begin
         exp_t e;
         e.data = mk_data(32'h8000_000C);
         e.pc   = 32'h8000_000C;
         exp_inst.push_back(e);
      end
      expect_fetch(32'h8000_0010, 1'b1);
      inst_ready = 1'b1;
      tick();
      check("bp_next_addr", mem_req_addr, 32'h8000_0010);
      drain("bp");

      // ---------------- 3: redirect during WAIT ----------------
      expect_fetch(32'h8000_0014, 1'b0);
      expect_fetch(32'h8000_0100, 1'b1);
      tick();
      redirect(32'h8000_0100);
      tick();
      check("rw_no_inst",   {31'b0, inst_valid},    0);
      check("rw_req_valid", {31'b0, mem_req_valid}, 1);
      check("rw_addr",      mem_req_addr,           32'h8000_0100);
      drain("rw");

      // ---------------- 4: redirect with handshake in HOLD ----------------
      expect_fetch(32'h8000_0104, 1'b0);
      wait_inst_valid("rh");
      check("rh_inst",    inst,    mk_data(32'h8000_0104));
      check("rh_inst_pc", inst_pc, 32'h8000_0104);
      expect_fetch(32'h8000_0200, 1'b1);
      redirect(32'h8000_0200);
      tick();
      check("rh_squash", {31'b0, inst_valid}, 0);
      check("rh_addr",   mem_req_addr,        32'h8000_0200);
      drain("rh");

      // ---------------- 5: request stall with redirect ----------------
      mem_req_ready = 1'b0;
      expect_fetch(32'h8000_0204, 1'b0);
      expect_fetch(32'h8000_0300, 1'b1);
      for (int i = 0; i < 4; i++) begin
         if (i == 2) redirect(32'h8000_0300);
         tick();
         check("st_req_held",  {31'b0, mem_req_valid}, 1);
         check("st_addr_held", mem_req_addr,           32'h8000_0204);
      end
      mem_req_ready = 1'b1;
      tick();
      tick();
      check("st_no_inst", {31'b0, inst_valid}, 0);
      check("st_addr",    mem_req_addr,        32'h8000_0300);
      drain("st");

      // ---------------- PC wrap at the top of the address space ----------------
      mem_req_ready = 1'b0;
      redirect(32'hFFFF_FFFC);
      tick();
      mem_req_ready = 1'b1;
      expect_fetch(32'h8000_0304, 1'b0);
      expect_fetch(32'hFFFF_FFFC, 1'b1);
      expect_fetch(32'h0000_0000, 1'b1);
      drain("wrap");

      // ---------------- 6: misaligned redirect ----------------
      mem_req_ready = 1'b0;
      redirect(32'h8000_0102);
      tick();
`ifdef IFU_MISALIGN_CHECK_EN
      check("mis_fault",  {31'b0, fault},         1);
      check("mis_no_req", {31'b0, mem_req_valid}, 0);
      mem_req_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("mis_fault_sticky", {31'b0, fault},         1);
         check("mis_still_no_req", {31'b0, mem_req_valid}, 0);
         check("mis_no_inst",      {31'b0, inst_valid},    0);
      end
`else
      check("mis_fault_tied", {31'b0, fault}, 0);
      check("mis_addr_held",  mem_req_addr,   32'h0000_0004);
      mem_req_ready = 1'b1;
      expect_fetch(32'h0000_0004, 1'b0);
      expect_fetch(32'h8000_0100, 1'b1);
      drain("mis");
`endif

      mem_req_ready = 1'b0;
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit: holds the PC, fetches 32-bit instructions from instruction memory over a valid/ready request plus response-valid interface, and presents each instruction with its PC to the IDU over a valid/ready handshake. It is the producer end of the `inst` interface the decoder consumes. Redirects from the execute stage, such as jumps and taken branches, change the fetch PC and squash any stale instruction.

## Interface
- `DATA_WIDTH`, 32, instruction and data width
- `RESET_PC`, 32'h8000_0000, first fetch address after reset
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `mem_req_valid`  out  1  fetch request valid
- `mem_req_ready`  in  1  memory accepts request
- `mem_req_addr`  out  32  fetch address, always 4-byte aligned
- `mem_rsp_valid`  in  1  response data valid; one response per accepted request, never in the acceptance cycle
- `mem_rsp_data`  in  DATA_WIDTH  fetched instruction
- `inst_valid`  out  1  instruction valid to IDU
- `inst_ready`  in  1  IDU accepts instruction
- `inst`  out  DATA_WIDTH  instruction to IDU
- `inst_pc`  out  32  PC of `inst`
- `redirect_valid`  in  1  one-cycle redirect pulse
- `redirect_pc`  in  32  redirect target
- `fault`  out  1  sticky misaligned-redirect flag; tied 0 without macro

## Operation
- FSM states:
  - IDLE: reset state.
  - REQ: `mem_req_valid`=1.
  - WAIT: request accepted, awaiting response.
  - HOLD: `inst_valid`=1.
  - FAULT: only with the macro.
- Transitions:
  - IDLE→REQ unconditionally.
  - REQ→WAIT on `mem_req_valid && mem_req_ready`.
  - WAIT→HOLD on `mem_rsp_valid` when not stale.
  - WAIT→REQ on `mem_rsp_valid` when stale. The response is discarded and `stale` is cleared.
  - HOLD→REQ on `inst_valid && inst_ready`, with pc ← pc+4.
- Registers:
  - `pc` is the address of the current fetch.
  - `tgt` holds the pending redirect target.
  - `stale` flags that the outstanding fetch must be discarded.
- `mem_req_addr`=`pc`. It is held stable while `mem_req_valid`=1 and not yet accepted. A pending request is never withdrawn.
- Redirect, by state:
  - IDLE: pc ← target.
  - REQ or WAIT: `tgt` ← target and `stale` ← 1. The in-flight request completes and its response is discarded. Next REQ uses `tgt`.
  - HOLD: `inst_valid` drops next cycle, pc ← target, state → REQ. The held instruction is squashed even if `inst_ready`=1 in the same cycle. Redirect wins; there is no pc+4 increment.
- Multiple redirects before resolution: the last target wins.
- Responses arriving outside WAIT are ignored.
- PC arithmetic: 32-bit, pc+4 wraps modulo 2^32 (32'hFFFF_FFFC → 0).

## Timing
- Reset values:
  - state=IDLE, pc=`RESET_PC`, `stale`=0.
  - `mem_req_valid`=0, `inst_valid`=0, `inst`=0, `inst_pc`=0, `fault`=0.
- First `mem_req_valid` is the first cycle after `rst` deasserts.
- Latency: request accepted at edge N, response at edge N+1 at the earliest, `inst_valid` high during cycle N+2.
- Minimum spacing between instructions is 3 cycles (REQ, WAIT, HOLD). There is no prefetch.
- `inst`/`inst_pc` are registered and stable while `inst_valid`=1 and not accepted.
- Redirect-to-first-request: the REQ with the new target is asserted at the latest the cycle after the stale response, or the cycle after the redirect when in IDLE or HOLD.
- Reset asserted mid-fetch: immediate return to reset values. An outstanding memory response after reset is ignored; memory must be reset together with the IFU.

## Configuration
- `IFU_MISALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0]`≠0 sends any state → FAULT.
  - In FAULT: `fault`=1 until reset, `mem_req_valid`=0 and `inst_valid`=0. Any outstanding response is ignored.
- Not defined:
  - `redirect_pc[1:0]` is forced to 2'b00 and fetch continues normally.
  - `fault` is tied 0.

## Structure
- Shared package `ypc_pkg`:
  - state enum {IDLE, REQ, WAIT, HOLD, FAULT}
  - `RESET_PC` default
  - `INST_BYTES`=4
- Single module. No sub-module; FSM plus PC/target registers are compact enough.

## Test plan
1. Reset, memory always ready, response 1 cycle later with data 32'h0000_0013, IDU always ready:
   - `mem_req_addr` sequence 8000_0000, 8000_0004, 8000_0008.
   - `inst_valid` every 3rd cycle with matching `inst_pc`.
2. IDU backpressure: `inst_ready`=0 for 5 cycles.
   - `inst`/`inst_pc` stay stable.
   - No new request is issued; next address is pc+4 only after the handshake.
3. Redirect to 8000_0100 during WAIT:
   - The response for the old fetch is discarded with no `inst_valid`.
   - The next request address is 8000_0100.
4. Redirect to 8000_0200 in the same cycle as an `inst` handshake in HOLD:
   - Next `mem_req_addr`=8000_0200, not pc+4.
5. `mem_req_ready`=0 for 4 cycles, then a redirect during the stall:
   - Address is held until acceptance.
   - The response is discarded and a new request goes to the target.
6. Redirect to 8000_0102:
   - With macro: `fault`=1, no further requests.
   - Without macro: fetch from 8000_0100.
